// File: rtl/hw_status_pkg.sv
// Shared definitions for the hardware manager status word: state encodings, status codes and
// field layout. Imported by the manager and by the status logger.
package hw_status_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd1,
    StPowerOn  = 4'd2,
    StStartDma = 4'd3,
    StStartSpi = 4'd4,
    StRunning  = 4'd5,
    StHalted   = 4'd6
  } hw_state_e;

  localparam int unsigned StatusWidth = 32;

  localparam int unsigned StateLsb = 0;
  localparam int unsigned StateMsb = 3;
  localparam int unsigned CodeLsb  = 4;
  localparam int unsigned CodeMsb  = 28;
  localparam int unsigned BoardLsb = 29;
  localparam int unsigned BoardMsb = 31;

  localparam logic [CodeMsb-CodeLsb:0] StatusCodeMin = 25'h1;
  localparam logic [CodeMsb-CodeLsb:0] StatusCodeMax = 25'hC;

  typedef struct packed {
    logic [BoardMsb-BoardLsb:0] board;
    logic [CodeMsb-CodeLsb:0]   code;
    logic [StateMsb-StateLsb:0] state;
  } status_word_t;

  localparam logic [StateMsb-StateLsb:0] StateResetVal = StIdle;

  function automatic logic [StateMsb-StateLsb:0] state_field(input logic [StatusWidth-1:0] w);
    return w[StateMsb:StateLsb];
  endfunction

  function automatic logic [CodeMsb-CodeLsb:0] code_field(input logic [StatusWidth-1:0] w);
    return w[CodeMsb:CodeLsb];
  endfunction

  function automatic logic [BoardMsb-BoardLsb:0] board_field(input logic [StatusWidth-1:0] w);
    return w[BoardMsb:BoardLsb];
  endfunction

  function automatic logic is_known_code(input logic [CodeMsb-CodeLsb:0] c);
    return (c >= StatusCodeMin) && (c <= StatusCodeMax);
  endfunction

endpackage

// File: rtl/status_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module status_fifo #(
  parameter int unsigned Width     = 64,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [Width-1:0]     wdata,
  output logic [Width-1:0]     rdata,
  output logic                 empty,
  output logic                 full,
  output logic [DepthLog2:0]   count
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] PtrOne = {{DepthLog2{1'b0}}, 1'b1};

  logic [DepthLog2:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2:0] rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                 (wr_ptr_q[DepthLog2-1:0] == rd_ptr_q[DepthLog2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DepthLog2-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[DepthLog2-1:0]];

endmodule

// File: rtl/hw_status_logger.sv
// Timestamped logger for hardware manager status reports. Captures each report (and optionally
// each state change) into a FWFT FIFO, tracks dropped events and raises a level irq.
module hw_status_logger
  import hw_status_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2          = 4,
  parameter int unsigned TS_WIDTH            = 32,
  parameter bit          LOG_ALL_TRANSITIONS = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [StatusWidth-1:0]     status_word,
  input  logic                       ps_interrupt,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  input  logic                       irq_en,
  output logic [StatusWidth+TS_WIDTH-1:0] rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [DEPTH_LOG2:0]        count,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       irq,
  output logic [TS_WIDTH-1:0]        timestamp_now
);

  localparam logic [TS_WIDTH-1:0] TsOne = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  logic [TS_WIDTH-1:0]        ts_q, ts_d;
  logic [StateMsb-StateLsb:0] prev_state_q, prev_state_d;
  logic                       overflow_q, overflow_d;
  logic [15:0]                drop_count_q, drop_count_d;
  logic                       irq_q, irq_d;

  logic [StateMsb-StateLsb:0] cur_state;
  logic                       state_changed;
  logic                       capture, push, pop, drop;
  logic                       fifo_empty, fifo_full;

  assign cur_state     = state_field(status_word);
  assign state_changed = LOG_ALL_TRANSITIONS && (cur_state != prev_state_q);
  assign capture       = ps_interrupt || state_changed;

  assign pop  = rd_en && !fifo_empty;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  always_comb begin
    ts_d         = ts_q + TsOne;
    prev_state_d = cur_state;
    irq_d        = irq_en && !fifo_empty;

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    // A drop on the clearing edge restarts the tally instead of being lost.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end else if (ovf_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      prev_state_q <= StateResetVal;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
      irq_q        <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      prev_state_q <= prev_state_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      irq_q        <= irq_d;
    end
  end

  status_fifo #(
    .Width     (StatusWidth + TS_WIDTH),
    .DepthLog2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({ts_q, status_word}),
    .rdata (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign empty         = fifo_empty;
  assign full          = fifo_full;
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;
  assign irq           = irq_q;
  assign timestamp_now = ts_q;

endmodule

// File: tb/tb_hw_status_logger.sv
// Directed bench for hw_status_logger: a small-depth, log-all-transitions instance is checked in
// detail; a default-parameter instance on the same inputs confirms transitions are ignored there.
module tb_hw_status_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] status_word;
  logic        ps_interrupt, rd_en, ovf_clr, irq_en;

  logic [63:0] rd_data;
  logic        empty, full, overflow, irq;
  logic [2:0]  count;
  logic [15:0] drop_count;
  logic [31:0] timestamp_now;

  logic [63:0] rd_data0;
  logic        empty0, full0, overflow0, irq0;
  logic [4:0]  count0;
  logic [15:0] drop_count0;
  logic [31:0] timestamp_now0;

  int unsigned tb_ts;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  hw_status_logger #(
    .DEPTH_LOG2          (2),
    .TS_WIDTH            (32),
    .LOG_ALL_TRANSITIONS (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .status_word   (status_word),
    .ps_interrupt  (ps_interrupt),
    .rd_en         (rd_en),
    .ovf_clr       (ovf_clr),
    .irq_en        (irq_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .irq           (irq),
    .timestamp_now (timestamp_now)
  );

  hw_status_logger dut0 (
    .clk           (clk),
    .rst           (rst),
    .status_word   (status_word),
    .ps_interrupt  (ps_interrupt),
    .rd_en         (rd_en),
    .ovf_clr       (ovf_clr),
    .irq_en        (irq_en),
    .rd_data       (rd_data0),
    .empty         (empty0),
    .full          (full0),
    .count         (count0),
    .overflow      (overflow0),
    .drop_count    (drop_count0),
    .irq           (irq0),
    .timestamp_now (timestamp_now0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    ps_interrupt = 1'b0;
    rd_en        = 1'b0;
    ovf_clr      = 1'b0;
    status_word  = 32'h1;
    step();
    step();
    rst   = 1'b0;
    tb_ts = 0;
  endtask

  function automatic logic [63:0] ent(input int unsigned ts, input logic [31:0] w);
    return {ts, w};
  endfunction

  initial begin
    int unsigned ta, t0, tc, tx;
    logic [63:0] exp_q [4];

    irq_en = 1'b1;
    do_reset();
    check_eq("rst_ts", timestamp_now, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drops", drop_count, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_rd_data", rd_data, 0);

    // Single report at timestamp 100
    repeat (100) step();
    check_eq("ts_100", timestamp_now, 100);
    status_word  = 32'h15;
    ps_interrupt = 1'b1;
    step();
    ps_interrupt = 1'b0;
    check_eq("one_data", rd_data, ent(100, 32'h15));
    check_eq("one_empty", empty, 0);
    check_eq("one_count", count, 1);
    check_eq("one_irq_lag", irq, 0);
    step();
    check_eq("one_irq", irq, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("pop_empty", empty, 1);
    check_eq("pop_rd_data", rd_data, 0);
    check_eq("pop_irq_lag", irq, 1);
    step();
    check_eq("pop_irq", irq, 0);

    // Back-to-back reports are distinct entries
    ta           = tb_ts;
    ps_interrupt = 1'b1;
    status_word  = 32'h15;
    step();
    status_word  = 32'h56;
    step();
    ps_interrupt = 1'b0;
    check_eq("b2b_count", count, 2);
    check_eq("b2b_first", rd_data, ent(ta, 32'h15));
    rd_en = 1'b1;
    step();
    check_eq("b2b_second", rd_data, ent(ta + 1, 32'h56));
    step();
    rd_en = 1'b0;
    check_eq("b2b_drained", empty, 1);

    // Overflow on a 4-deep FIFO
    do_reset();
    irq_en       = 1'b0;
    t0           = tb_ts;
    ps_interrupt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      status_word = (i << 4) | 32'h1;
      step();
    end
    ps_interrupt = 1'b0;
    check_eq("ovf_count", count, 4);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drops", drop_count, 2);
    check_eq("ovf_head", rd_data, ent(t0, 32'h01));
    check_eq("irq_disabled", irq, 0);
    irq_en = 1'b1;
    step();
    check_eq("irq_enabled", irq, 1);

    tc           = tb_ts;
    ps_interrupt = 1'b1;
    rd_en        = 1'b1;
    status_word  = 32'h71;
    step();
    rd_en = 1'b0;
    check_eq("full_pushpop_count", count, 4);
    check_eq("full_pushpop_drops", drop_count, 2);
    check_eq("full_pushpop_head", rd_data, ent(t0 + 1, 32'h11));
    status_word = 32'h81;
    ovf_clr     = 1'b1;
    step();
    ps_interrupt = 1'b0;
    check_eq("clr_drop_flag", overflow, 1);
    check_eq("clr_drop_count", drop_count, 1);
    step();
    ovf_clr = 1'b0;
    check_eq("clr_flag", overflow, 0);
    check_eq("clr_count", drop_count, 0);

    exp_q[0] = ent(t0 + 1, 32'h11);
    exp_q[1] = ent(t0 + 2, 32'h21);
    exp_q[2] = ent(t0 + 3, 32'h31);
    exp_q[3] = ent(tc, 32'h71);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_%0d", i), rd_data, exp_q[i]);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check_eq("drain_empty", empty, 1);

    // State-change capture without interrupts
    do_reset();
    status_word = 32'h6;
    step();
    check_eq("tr_first_count", count, 1);
    rd_en = 1'b1;
    step();
    rd_en       = 1'b0;
    tx          = tb_ts;
    status_word = 32'h1;
    step();
    check_eq("tr_count", count, 1);
    check_eq("tr_data", rd_data, ent(tx, 32'h1));
    check_eq("tr_ignored_default", empty0, 1);
    step();
    check_eq("tr_steady", count, 1);
    ps_interrupt = 1'b1;
    status_word  = 32'h5;
    step();
    ps_interrupt = 1'b0;
    check_eq("tr_irq_merge", count, 2);
    step();
    check_eq("tr_irq_merge_hold", count, 2);

    // Reset with entries stored
    ps_interrupt = 1'b1;
    step();
    ps_interrupt = 1'b0;
    check_eq("pre_rst_count", count, 3);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    tb_ts = 0;
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_irq", irq, 0);
    check_eq("mid_rst_ts", timestamp_now, 0);
    check_eq("mid_rst_rd_data", rd_data, 0);

    // Pop on empty is ignored, also when a capture arrives with it
    status_word = 32'h1;
    rd_en       = 1'b1;
    step();
    check_eq("pop_empty_count", count, 0);
    check_eq("pop_empty_flag", empty, 1);
    tx           = tb_ts;
    ps_interrupt = 1'b1;
    step();
    ps_interrupt = 1'b0;
    rd_en        = 1'b0;
    check_eq("empty_pushpop_count", count, 1);
    check_eq("empty_pushpop_data", rd_data, ent(tx, 32'h1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
